// File: rtl/sprite_compositor_if.sv
// sprite_compositor_if: pixel-stream and collision signals between the
// sprite drawers, the compositor and the VGA output stage.
`default_nettype none

interface sprite_compositor_if #(
  parameter int NUM_SPR = 4,
  parameter int COLOR_W = 8
);
  logic                       frame_start;
  logic                       video_on;
  logic [NUM_SPR-1:0]         spr_draw;
  logic [NUM_SPR-1:0]         spr_enable;
  logic [NUM_SPR*COLOR_W-1:0] spr_color;
  logic [COLOR_W-1:0]         rgb;
  logic                       rgb_valid;
  logic [NUM_SPR-1:0]         coll_flags;
  logic                       coll_irq;

  modport master (
    output frame_start, video_on, spr_draw, spr_enable, spr_color,
    input  rgb, rgb_valid, coll_flags, coll_irq
  );

  modport slave (
    input  frame_start, video_on, spr_draw, spr_enable, spr_color,
    output rgb, rgb_valid, coll_flags, coll_irq
  );
endinterface

`default_nettype wire

// File: rtl/sprite_compositor.sv
// ============================================================================
// Module  : sprite_compositor
// Brief   : Fixed-priority RGB332 sprite merge (2-cycle latency) with
//           per-frame sprite overlap flags (built when COMPOSITOR_COLLISION_EN
//           is defined).
// Revision: 1.0
// ============================================================================
`default_nettype none

module sprite_compositor #(
  parameter int                 NUM_SPR  = 4,
  parameter int                 COLOR_W  = 8,
  parameter logic [COLOR_W-1:0] BG_COLOR = {COLOR_W{1'b0}}
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  sprite_compositor_if.slave bus
);

  logic [NUM_SPR-1:0]         w_eff;
  logic [NUM_SPR-1:0]         r_s1_eff;
  logic [NUM_SPR*COLOR_W-1:0] r_s1_color;
  logic                       r_s1_video;
  logic [COLOR_W-1:0]         w_pix;
  logic [COLOR_W-1:0]         r_rgb;
  logic                       r_rgb_valid;

  assign w_eff = bus.spr_draw & bus.spr_enable & {NUM_SPR{bus.video_on}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_eff   <= '0;
      r_s1_color <= '0;
      r_s1_video <= 1'b0;
    end else begin
      r_s1_eff   <= w_eff;
      r_s1_color <= bus.spr_color;
      r_s1_video <= bus.video_on;
    end
  end

  // Scan from the top so the lowest lit index is the last (winning) write.
  always_comb begin
    w_pix = BG_COLOR;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (r_s1_eff[i]) w_pix = r_s1_color[i*COLOR_W +: COLOR_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb       <= '0;
      r_rgb_valid <= 1'b0;
    end else begin
      r_rgb       <= r_s1_video ? w_pix : '0;
      r_rgb_valid <= r_s1_video;
    end
  end

  assign bus.rgb       = r_rgb;
  assign bus.rgb_valid = r_rgb_valid;

`ifdef COMPOSITOR_COLLISION_EN
  localparam int c_cnt_w = $clog2(NUM_SPR + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_s1_fs;
  logic [c_cnt_w-1:0] w_cnt;
  logic               w_overlap;
  logic [NUM_SPR-1:0] r_acc;
  logic [NUM_SPR-1:0] r_coll_flags;
  logic               r_coll_irq;

  // frame_start rides with S1 so an overlap entering on the same input
  // cycle is still counted in the frame that is closing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_s1_fs <= 1'b0;
    else        r_s1_fs <= bus.frame_start;
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      w_cnt = w_cnt + c_cnt_w'(r_s1_eff[i]);
    end
  end

  assign w_overlap = (w_cnt >= c_cnt_w'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_s1_fs) w_next = S_ACCUM;
      S_ACCUM: if (r_s1_fs) w_next = S_LATCH;
      S_LATCH: w_next = S_ACCUM;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_coll_flags <= '0;
      r_coll_irq   <= 1'b0;
    end else begin
      r_coll_irq <= 1'b0;
      case (r_state)
        S_ACCUM: if (w_overlap) r_acc <= r_acc | r_s1_eff;
        S_LATCH: begin
          r_coll_flags <= r_acc;
          r_coll_irq   <= |r_acc;
          r_acc        <= w_overlap ? r_s1_eff : '0;
        end
        default: r_acc <= '0;
      endcase
    end
  end

  assign bus.coll_flags = r_coll_flags;
  assign bus.coll_irq   = r_coll_irq;
`else
  assign bus.coll_flags = '0;
  assign bus.coll_irq   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sprite_compositor.sv
// Directed-vector bench for sprite_compositor; collision expectations follow
// whether COMPOSITOR_COLLISION_EN is defined for this build.
`default_nettype none

module tb_sprite_compositor;
  localparam int         NUM_SPR = 4;
  localparam int         COLOR_W = 8;
  localparam logic [7:0] BG      = 8'h25;
`ifdef COMPOSITOR_COLLISION_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [3:0] e_flags;
  logic       e_irq;

  sprite_compositor_if #(.NUM_SPR(NUM_SPR), .COLOR_W(COLOR_W)) bus ();

  sprite_compositor #(.NUM_SPR(NUM_SPR), .COLOR_W(COLOR_W), .BG_COLOR(BG)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // frame_start for one cycle; returns just after the LATCH result lands.
  task automatic pulse_fs();
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    bus.frame_start = 0; bus.video_on = 0; bus.spr_draw = 0; bus.spr_enable = 0;
    bus.spr_color = {8'hFF, 8'hE0, 8'h1C, 8'h03};
    #3;
    total++; if (bus.rgb !== 8'h00) begin bad++; $display("FAIL rst_rgb got=%h exp=00", bus.rgb); end
    total++; if (bus.rgb_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.rgb_valid); end
    total++; if (bus.coll_irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", bus.coll_irq); end
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      total++; if (bus.rgb !== 8'h00) begin bad++; $display("FAIL idle_rgb cyc=%0d got=%h exp=00", i, bus.rgb); end
      total++; if (bus.rgb_valid !== 1'b0) begin bad++; $display("FAIL idle_valid cyc=%0d got=%b exp=0", i, bus.rgb_valid); end
      total++; if (bus.coll_flags !== 4'h0) begin bad++; $display("FAIL idle_flags cyc=%0d got=%b exp=0000", i, bus.coll_flags); end
    end
  endtask

  task automatic test_composite();
    bus.video_on = 1; bus.spr_draw = 4'b0100; bus.spr_enable = 4'hF;
    step();
    total++; if (bus.rgb_valid !== 1'b0) begin bad++; $display("FAIL lat1_valid got=%b exp=0", bus.rgb_valid); end
    total++; if (bus.rgb !== 8'h00) begin bad++; $display("FAIL lat1_rgb got=%h exp=00", bus.rgb); end
    step();
    total++; if (bus.rgb !== 8'hE0) begin bad++; $display("FAIL single_rgb got=%h exp=e0", bus.rgb); end
    total++; if (bus.rgb_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", bus.rgb_valid); end
    bus.spr_draw = 4'b0000;
    step(); step();
    total++; if (bus.rgb !== BG) begin bad++; $display("FAIL bg_rgb got=%h exp=%h", bus.rgb, BG); end
  endtask

  task automatic test_priority();
    bus.spr_draw = 4'b0110;
    step(); step();
    total++; if (bus.rgb !== 8'h1C) begin bad++; $display("FAIL prio_rgb got=%h exp=1c", bus.rgb); end
    bus.spr_enable = 4'b1101;
    step(); step();
    total++; if (bus.rgb !== 8'hE0) begin bad++; $display("FAIL prio_en_rgb got=%h exp=e0", bus.rgb); end
    bus.spr_enable = 4'hF; bus.spr_draw = 4'b1000;
    step(); step();
    total++; if (bus.rgb !== 8'hFF) begin bad++; $display("FAIL top_rgb got=%h exp=ff", bus.rgb); end
    bus.video_on = 0; bus.spr_draw = 4'hF;
    step(); step();
    total++; if (bus.rgb !== 8'h00) begin bad++; $display("FAIL blank_rgb got=%h exp=00", bus.rgb); end
    total++; if (bus.rgb_valid !== 1'b0) begin bad++; $display("FAIL blank_valid got=%b exp=0", bus.rgb_valid); end
    bus.video_on = 1; bus.spr_draw = 0;
    step(); step();
  endtask

  task automatic test_collision();
    pulse_fs();
    bus.spr_draw = 4'b0011;
    step();
    bus.spr_draw = 4'b0000;
    step(); step();
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    total++; if (bus.coll_irq !== 1'b0) begin bad++; $display("FAIL irq_early1 got=%b exp=0", bus.coll_irq); end
    step();
    total++; if (bus.coll_irq !== 1'b0) begin bad++; $display("FAIL irq_early2 got=%b exp=0", bus.coll_irq); end
    step();
    e_flags = COLL ? 4'b0011 : 4'b0000; e_irq = COLL;
    total++; if (bus.coll_flags !== e_flags) begin bad++; $display("FAIL latch_flags got=%b exp=%b", bus.coll_flags, e_flags); end
    total++; if (bus.coll_irq !== e_irq) begin bad++; $display("FAIL latch_irq got=%b exp=%b", bus.coll_irq, e_irq); end
    step();
    total++; if (bus.coll_irq !== 1'b0) begin bad++; $display("FAIL irq_width got=%b exp=0", bus.coll_irq); end
    total++; if (bus.coll_flags !== e_flags) begin bad++; $display("FAIL flags_hold got=%b exp=%b", bus.coll_flags, e_flags); end
    bus.spr_draw = 4'b0001;
    step(); step();
    bus.spr_draw = 4'b0000;
    pulse_fs();
    total++; if (bus.coll_flags !== 4'b0000) begin bad++; $display("FAIL quiet_flags got=%b exp=0000", bus.coll_flags); end
    total++; if (bus.coll_irq !== 1'b0) begin bad++; $display("FAIL quiet_irq got=%b exp=0", bus.coll_irq); end
    step();
    total++; if (bus.coll_irq !== 1'b0) begin bad++; $display("FAIL quiet_irq2 got=%b exp=0", bus.coll_irq); end
  endtask

  task automatic test_same_cycle();
    bus.frame_start = 1'b1; bus.spr_draw = 4'b1001;
    step();
    bus.frame_start = 1'b0; bus.spr_draw = 4'b0000;
    step(); step();
    e_flags = COLL ? 4'b1001 : 4'b0000; e_irq = COLL;
    total++; if (bus.coll_flags !== e_flags) begin bad++; $display("FAIL same_flags got=%b exp=%b", bus.coll_flags, e_flags); end
    total++; if (bus.coll_irq !== e_irq) begin bad++; $display("FAIL same_irq got=%b exp=%b", bus.coll_irq, e_irq); end
    step();
    // overlap while blanked, then one landing in the LATCH cycle
    bus.video_on = 0; bus.spr_draw = 4'b0110;
    step();
    bus.video_on = 1; bus.spr_draw = 4'b0000;
    step();
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0; bus.spr_draw = 4'b0101;
    step();
    bus.spr_draw = 4'b0000;
    step();
    total++; if (bus.coll_flags !== 4'b0000) begin bad++; $display("FAIL blank_coll got=%b exp=0000", bus.coll_flags); end
    total++; if (bus.coll_irq !== 1'b0) begin bad++; $display("FAIL blank_irq got=%b exp=0", bus.coll_irq); end
    step(); step();
    pulse_fs();
    e_flags = COLL ? 4'b0101 : 4'b0000;
    total++; if (bus.coll_flags !== e_flags) begin bad++; $display("FAIL latchcyc_flags got=%b exp=%b", bus.coll_flags, e_flags); end
    step();
  endtask

  task automatic test_reset_mid();
    bus.spr_draw = 4'b0011;
    step(); step();
    total++; if (bus.rgb !== 8'h03) begin bad++; $display("FAIL pre_rst_rgb got=%h exp=03", bus.rgb); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.rgb !== 8'h00) begin bad++; $display("FAIL async_rgb got=%h exp=00", bus.rgb); end
    total++; if (bus.rgb_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b exp=0", bus.rgb_valid); end
    total++; if (bus.coll_flags !== 4'b0000) begin bad++; $display("FAIL async_flags got=%b exp=0000", bus.coll_flags); end
    bus.spr_draw = 0; bus.video_on = 0;
    step();
    rst_n = 1'b1;
    step();
    total++; if (bus.rgb !== 8'h00) begin bad++; $display("FAIL post_rst_rgb got=%h exp=00", bus.rgb); end
    bus.video_on = 1;
    pulse_fs();
    total++; if (bus.coll_flags !== 4'b0000) begin bad++; $display("FAIL rst_fs1_flags got=%b exp=0000", bus.coll_flags); end
    total++; if (bus.coll_irq !== 1'b0) begin bad++; $display("FAIL rst_fs1_irq got=%b exp=0", bus.coll_irq); end
    step(); step();
    pulse_fs();
    total++; if (bus.coll_flags !== 4'b0000) begin bad++; $display("FAIL rst_fs2_flags got=%b exp=0000", bus.coll_flags); end
    total++; if (bus.coll_irq !== 1'b0) begin bad++; $display("FAIL rst_fs2_irq got=%b exp=0", bus.coll_irq); end
  endtask

  initial begin
    test_reset();
    test_composite();
    test_priority();
    test_collision();
    test_same_cycle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
